// File: rtl/nco_pkg.sv
// Shared types and constants for the phase-accumulator NCO: FSM states,
// default angle width and the dither LFSR polynomial/seed.
package nco_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } nco_state_e;

   localparam int unsigned ANGLE_W_DEF     = 32;
   localparam int unsigned DITHER_BITS_DEF = 4;

   // x^16 + x^14 + x^13 + x^11 + 1 as state-bit taps 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/phase_accum_nco_lfsr16.sv
// 16-bit Fibonacci LFSR used for angle dither; loads the seed on reset and
// advances one step per enabled cycle.
module lfsr16
   import nco_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] lfsr_state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_state <= SEED;
      end else if (en) begin
         lfsr_state <= lfsr_step(lfsr_state);
      end
   end

endmodule

// File: rtl/phase_accum_nco.sv
// Burst/continuous phase-accumulator NCO with valid/ready angle output.
// Optional angle dither is enabled by defining PHASE_DITHER_EN.
module phase_accum_nco
   import nco_pkg::*;
#(
   parameter int unsigned ANGLE_W     = ANGLE_W_DEF,
   parameter int unsigned DITHER_BITS = DITHER_BITS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [ANGLE_W-1:0] cfg_ftw,
   input  logic [ANGLE_W-1:0] cfg_offset,
   input  logic [15:0]        cfg_len,
   input  logic               start,
   input  logic               stop,
   output logic [ANGLE_W-1:0] angle_o,
   output logic               angle_valid_o,
   input  logic               angle_ready_i,
   output logic               busy_o,
   output logic               done_o
);

   nco_state_e         state;
   logic [ANGLE_W-1:0] ftw_q;
   logic [ANGLE_W-1:0] offset_q;
   logic [ANGLE_W-1:0] acc_q;
   logic [ANGLE_W-1:0] acc_next;
   logic [15:0]        len_q;
   logic [15:0]        cnt_q;
   logic               stop_pend;
   logic               xfer;
   logic               last_beat;
   logic [ANGLE_W-1:0] dither_cur;
   logic [ANGLE_W-1:0] dither_next;

   assign xfer = angle_valid_o && angle_ready_i;

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr_state;
   logic [15:0] lfsr_next;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (xfer),
      .lfsr_state (lfsr_state)
   );

   // The registered angle for the next beat must use the post-advance LFSR value.
   always_comb begin
      lfsr_next   = lfsr_step(lfsr_state);
      dither_cur  = ANGLE_W'(lfsr_state[DITHER_BITS-1:0]);
      dither_next = ANGLE_W'(lfsr_next[DITHER_BITS-1:0]);
   end
`else
   assign dither_cur  = '0;
   assign dither_next = '0;
`endif

   always_comb begin
      acc_next  = acc_q + ftw_q;
      last_beat = ((len_q != '0) && (cnt_q == len_q - 16'd1)) || stop_pend || stop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ftw_q         <= '0;
         offset_q      <= '0;
         len_q         <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         stop_pend     <= 1'b0;
         angle_o       <= '0;
         angle_valid_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cfg_we) begin
                  ftw_q    <= cfg_ftw;
                  offset_q <= cfg_offset;
                  len_q    <= cfg_len;
               end
               if (start) begin
                  acc_q         <= '0;
                  cnt_q         <= '0;
                  stop_pend     <= 1'b0;
                  angle_o       <= offset_q + dither_cur;
                  angle_valid_o <= 1'b1;
                  busy_o        <= 1'b1;
                  state         <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  stop_pend <= 1'b1;
               end
               if (xfer) begin
                  acc_q <= acc_next;
                  cnt_q <= cnt_q + 16'd1;
                  if (last_beat) begin
                     angle_valid_o <= 1'b0;
                     busy_o        <= 1'b0;
                     done_o        <= 1'b1;
                     stop_pend     <= 1'b0;
                     state         <= ST_DONE;
                  end else begin
                     angle_o <= offset_q + acc_next + dither_next;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_accum_nco.sv
// Randomized self-checking bench for phase_accum_nco against an arithmetic
// model: beat k of a burst carries offset + k*ftw (plus dither when enabled).
module tb_phase_accum_nco;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic [AW-1:0] cfg_ftw;
   logic [AW-1:0] cfg_offset;
   logic [15:0]   cfg_len;
   logic          start;
   logic          stop;
   logic [AW-1:0] angle_o;
   logic          angle_valid_o;
   logic          angle_ready_i;
   logic          busy_o;
   logic          done_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] m_ftw, m_off;
   logic [15:0] m_len;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   phase_accum_nco #(.ANGLE_W(AW), .DITHER_BITS(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_we        (cfg_we),
      .cfg_ftw       (cfg_ftw),
      .cfg_offset    (cfg_offset),
      .cfg_len       (cfg_len),
      .start         (start),
      .stop          (stop),
      .angle_o       (angle_o),
      .angle_valid_o (angle_valid_o),
      .angle_ready_i (angle_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_angle(input int k);
      logic [31:0] a;
      a = m_off + m_ftw * 32'(k);
`ifdef PHASE_DITHER_EN
      a = a + {28'd0, m_lfsr[3:0]};
`endif
      return a;
   endfunction

   // Polynomial x^16+x^14+x^13+x^11+1, shifting toward the MSB.
   function automatic logic [15:0] model_lfsr_adv(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   task automatic do_cfg(input logic [31:0] ftw, input logic [31:0] off, input logic [15:0] len);
      cfg_we = 1'b1; cfg_ftw = ftw; cfg_offset = off; cfg_len = len;
      @(negedge clk);
      cfg_we = 1'b0;
      m_ftw = ftw; m_off = off; m_len = len;
   endtask

   // ready_mode: 0 always ready, 1 random, 2 low 3 cycles while beat 1 shown,
   // 3 low for 3 cycles starting at stop_at.
   task automatic run_burst(input int ready_mode, input int stop_at,
                            input bit start_with_stop, input bit cfg_in_run);
      int          k;
      bit          stop_req, ending, fin, hold, r;
      int          low_cnt;
      logic [31:0] prev_angle;
      k = 0; stop_req = 0; ending = 0; fin = 0; hold = 0; low_cnt = 0; prev_angle = '0;
      if (m_len == 0 && stop_at < 0) stop_at = 4;
      start = 1'b1;
      stop  = start_with_stop;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         if (ending) begin
            check("done_pulse", {31'd0, done_o}, 32'd1);
            check("valid_end", {31'd0, angle_valid_o}, 32'd0);
            check("busy_end", {31'd0, busy_o}, 32'd0);
            @(negedge clk);
            check("done_single", {31'd0, done_o}, 32'd0);
            check("busy_idle", {31'd0, busy_o}, 32'd0);
            fin = 1;
         end else begin
            check("valid_run", {31'd0, angle_valid_o}, 32'd1);
            check("busy_run", {31'd0, busy_o}, 32'd1);
            check("no_early_done", {31'd0, done_o}, 32'd0);
            check($sformatf("angle_beat%0d", k), angle_o, exp_angle(k));
            if (hold) check("angle_hold", angle_o, prev_angle);
            if (cyc == stop_at) begin
               stop = 1'b1;
               stop_req = 1;
            end
            if (cfg_in_run && cyc == 1) begin
               cfg_we = 1'b1; cfg_ftw = ~m_ftw; cfg_offset = ~m_off; cfg_len = 16'd1;
            end
            if (ready_mode == 1 && $urandom_range(0, 7) == 0) start = 1'b1;
            case (ready_mode)
               0:       r = 1;
               1:       r = ($urandom_range(0, 2) != 0);
               2:       r = !(k == 1 && low_cnt < 3);
               default: r = !(stop_at >= 0 && cyc >= stop_at && cyc < stop_at + 3);
            endcase
            if (!r) low_cnt++;
            angle_ready_i = r;
            if (r) begin
               if ((m_len != 0 && k + 1 == int'(m_len)) || stop_req) ending = 1;
               k++;
               m_lfsr = model_lfsr_adv(m_lfsr);
            end
            hold = !r;
            prev_angle = angle_o;
            @(negedge clk);
            stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
         end
      end
      if (!fin) check("burst_timeout", 32'd0, 32'd1);
      if (m_len != 0 && stop_at < 0) check("beat_count", 32'(k), {16'd0, m_len});
   endtask

   initial begin
      cfg_we = 0; cfg_ftw = '0; cfg_offset = '0; cfg_len = '0;
      start = 0; stop = 0; angle_ready_i = 1;
      m_ftw = '0; m_off = '0; m_len = '0; m_lfsr = 16'hACE1;
      rst_n = 0;
      repeat (3) @(negedge clk);
      check("rst_angle", angle_o, 32'd0);
      check("rst_valid", {31'd0, angle_valid_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      rst_n = 1;
      @(negedge clk);

      // Quarter-turn steps, then half-turn with wrap.
      do_cfg(32'h4000_0000, 32'h0, 16'd4);
      run_burst(0, -1, 0, 0);
      do_cfg(32'h8000_0000, 32'h1000_0000, 16'd3);
      run_burst(0, -1, 1, 0);
      // Back-pressure while the second beat is presented.
      do_cfg(32'h4000_0000, 32'h0, 16'd4);
      run_burst(2, -1, 0, 0);
      // Continuous mode stopped under back-pressure; config write in RUN ignored.
      do_cfg(32'h0123_4567, 32'h0000_0100, 16'd0);
      run_burst(3, 5, 0, 1);
      run_burst(0, 2, 0, 0);
      // Stop coincident with the final beat.
      do_cfg(32'h0000_1000, 32'h5, 16'd3);
      run_burst(0, 2, 0, 0);

      for (int i = 0; i < 10; i++) begin
         do_cfg($urandom, $urandom, 16'($urandom_range(0, 6)));
         run_burst(1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1,
                   bit'($urandom_range(0, 1)), 0);
      end

      // Asynchronous reset in the middle of a burst.
      do_cfg(32'h1111_1111, 32'h2222_2222, 16'd20);
      angle_ready_i = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("arst_angle", angle_o, 32'd0);
      check("arst_valid", {31'd0, angle_valid_o}, 32'd0);
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_done", {31'd0, done_o}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      m_ftw = '0; m_off = '0; m_len = '0; m_lfsr = 16'hACE1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_done", {31'd0, done_o}, 32'd0);
      end
      run_burst(0, 3, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
